// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO, depth 2**W, registered occupancy and status flags.
// Define FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags cleared by err_clr.
module sync_fifo_param #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_LVL = 2**W-2,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         err_clr,
  output logic [B-1:0] r_data,
  output logic         valid,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0]   DEPTH_C   = (W+1)'(2**W);
  localparam logic [W:0]   AF_C      = (W+1)'(AF_LVL);
  localparam logic [W:0]   AE_C      = (W+1)'(AE_LVL);
  localparam logic [W:0]   ZERO_C    = {(W+1){1'b0}};
  localparam logic [W:0]   CNT_ONE_C = (W+1)'(1'b1);
  localparam logic [W-1:0] PTR_ONE_C = W'(1'b1);

  logic [B-1:0] mem_r [0:(2**W)-1];
  logic [W-1:0] rd_ptr_r;
  logic [W-1:0] wr_ptr_r;
  logic [W:0]   count_r;
  logic [W:0]   count_nxt_s;
  logic         empty_r;
  logic         full_r;
  logic         almost_empty_r;
  logic         almost_full_r;
  logic         rd_acc_s;
  logic         wr_acc_s;

  // A write is still taken when full as long as a read frees the head slot this cycle
  assign rd_acc_s = rd & ~empty_r;
  assign wr_acc_s = wr & (~full_r | rd);

  assign r_data       = mem_r[rd_ptr_r];
  assign valid        = rd_acc_s;
  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_empty = almost_empty_r;
  assign almost_full  = almost_full_r;
  assign count        = count_r;

  // Next occupancy from the accepted read/write pair
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE_C;
      2'b01:   count_nxt_s = count_r - CNT_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array, deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= w_data;
    end
  end

  // Pointers, occupancy and flags all derive from the next-state count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r       <= {W{1'b0}};
      wr_ptr_r       <= {W{1'b0}};
      count_r        <= ZERO_C;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_empty_r <= 1'b1;
      almost_full_r  <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      count_r        <= count_nxt_s;
      empty_r        <= (count_nxt_s == ZERO_C);
      full_r         <= (count_nxt_s == DEPTH_C);
      almost_empty_r <= (count_nxt_s <= AE_C);
      almost_full_r  <= (count_nxt_s >= AF_C);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= (wr & ~wr_acc_s) | (overflow_r & ~err_clr);
      underflow_r <= (rd & ~rd_acc_s) | (underflow_r & ~err_clr);
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  logic unused_err_clr_s;

  assign unused_err_clr_s = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-model bench for sync_fifo_param (B=8, W=3, AF_LVL=6, AE_LVL=2).
// Directed scenarios pin the model with literals; a random phase exercises the rest.
module tb_sync_fifo_param;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rd, wr, err_clr;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0] count;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  bit         ovf_m, udf_m;
  logic       last_valid;
  logic [7:0] last_rdata;

  sync_fifo_param #(.B(8), .W(3), .AF_LVL(6), .AE_LVL(2)) dut (
    .clk(clk), .reset_n(reset_n), .rd(rd), .wr(wr), .w_data(w_data), .err_clr(err_clr),
    .r_data(r_data), .valid(valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every output compared against the queue model with the current inputs applied
  task automatic compare_outputs();
    bit exp_valid;
    exp_valid = rd && (q.size() > 0);
    last_valid = valid;
    last_rdata = r_data;
    chk("valid", valid, exp_valid);
    if (exp_valid) chk("r_data", r_data, q[0]);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("almost_empty", almost_empty, q.size() <= AE);
    chk("almost_full", almost_full, q.size() >= AF);
    chk("overflow", overflow, ERR_EN ? ovf_m : 1'b0);
    chk("underflow", underflow, ERR_EN ? udf_m : 1'b0);
  endtask

  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit clr = 1'b0);
    bit ra, wa;
    @(negedge clk);
    wr = w; rd = r; w_data = d; err_clr = clr;
    #1;
    compare_outputs();
    @(posedge clk);
    #1;
    ra = r && (q.size() > 0);
    wa = w && ((q.size() < DEPTH) || r);
    ovf_m = (w && !wa) || (ovf_m && !clr);
    udf_m = (r && !ra) || (udf_m && !clr);
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(d);
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rd = 1'b1; wr = 1'b0; err_clr = 1'b0; w_data = 8'h00;
    ovf_m = 1'b0; udf_m = 1'b0;
    #12;
    chk("rst_count", count, 32'd0);
    chk("rst_empty", empty, 32'd1);
    chk("rst_ae", almost_empty, 32'd1);
    chk("rst_full", full, 32'd0);
    chk("rst_af", almost_full, 32'd0);
    chk("rst_valid", valid, 32'd0);
    chk("rst_ovf", overflow, 32'd0);
    chk("rst_udf", underflow, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; rd = 1'b0;

    // Fill with 0x01..0x08 and watch the thresholds cross
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk("fill_count", count, 32'(i));
      chk("fill_ae", almost_empty, (i < 3) ? 32'd1 : 32'd0);
      chk("fill_af", almost_full, (i >= 6) ? 32'd1 : 32'd0);
      chk("fill_full", full, (i == 8) ? 32'd1 : 32'd0);
    end

    // Rejected write while full, then clear the sticky flag
    step(1'b1, 1'b0, 8'hAA);
    chk("ovf_count", count, 32'd8);
    chk("ovf_flag", overflow, ERR_EN ? 32'd1 : 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", overflow, 32'd0);

    // Simultaneous read/write while full
    step(1'b1, 1'b1, 8'h09);
    chk("fullrw_valid", last_valid, 32'd1);
    chk("fullrw_rdata", last_rdata, 32'h01);
    chk("fullrw_count", count, 32'd8);
    chk("fullrw_full", full, 32'd1);
    for (int i = 2; i <= 9; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_rdata", last_rdata, 32'(i));
    end
    chk("drain_empty", empty, 32'd1);

    // Simultaneous read/write while empty
    step(1'b1, 1'b1, 8'h55);
    chk("emptyrw_valid", last_valid, 32'd0);
    chk("emptyrw_count", count, 32'd1);
    chk("emptyrw_empty", empty, 32'd0);
    step(1'b0, 1'b1, 8'h00);
    chk("emptyrw_rd_valid", last_valid, 32'd1);
    chk("emptyrw_rd_data", last_rdata, 32'h55);
    chk("emptyrw_after", empty, 32'd1);

    // Underflow on empty read, cleared afterwards
    step(1'b0, 1'b1, 8'h00);
    chk("udf_flag", underflow, ERR_EN ? 32'd1 : 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Alternate write/read so pointers wrap twice
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'($urandom_range(255)));
      chk("wrap_not_full", full, 32'd0);
      step(1'b0, 1'b1, 8'h00);
      chk("wrap_empty", empty, 32'd1);
    end

    // Random traffic with a drifting write/read bias
    for (int blk = 0; blk < 8; blk++) begin
      int wp;
      wp = (blk % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 50; i++) begin
        step(($urandom_range(99) < wp), ($urandom_range(99) < (100 - wp)),
             8'($urandom_range(255)), ($urandom_range(99) < 5));
      end
    end

    // Reset mid-stream at count 5
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    chk("pre_rst_count", count, 32'd5);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 32'd0);
    chk("mid_rst_empty", empty, 32'd1);
    chk("mid_rst_af", almost_full, 32'd0);
    q.delete();
    ovf_m = 1'b0; udf_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_valid", last_valid, 32'd0);
    chk("post_rst_udf", underflow, ERR_EN ? 32'd1 : 32'd0);
    step(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter B, default 8, data word width in bits.
REQ-002 The block SHALL have parameter W, default 4, address bits; depth = 2**W words.
REQ-003 The block SHALL have parameter AF_LVL, default 2**W-2, almost_full threshold in words.
REQ-004 The block SHALL have parameter AE_LVL, default 2, almost_empty threshold in words.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have ports rd, wr, input, 1 bit each: read and write requests.
REQ-008 The block SHALL have port w_data, input, B bits: write word.
REQ-009 The block SHALL have port r_data, output, B bits: head-of-queue word, combinational from storage.
REQ-010 The block SHALL have port valid, output, 1 bit: combinational; high when a read is accepted this cycle.
REQ-011 The block SHALL have ports empty, full, almost_empty, almost_full, output, 1 bit each: registered status flags.
REQ-012 The block SHALL have port count, output, W+1 bits: registered occupancy, 0..2**W.
REQ-013 The block SHALL have ports overflow, underflow, output, 1 bit each, and err_clr, input, 1 bit (see Configuration).

Function
REQ-014 Read accepted SHALL be rd & ~empty; write accepted SHALL be wr & (~full | rd).
REQ-015 An accepted read SHALL assert valid in the same cycle with r_data = head word; the read pointer advances at the next edge.
REQ-016 An accepted write SHALL store w_data at the write pointer at the next edge; the write pointer advances.
REQ-017 Pointers SHALL wrap modulo 2**W with no dead entry.
REQ-018 count SHALL be +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-019 wr&rd while empty: write accepted, read rejected, valid=0, count 0->1, empty deasserts next cycle.
REQ-020 wr&rd while full: both accepted, count stays 2**W, full stays high; r_data in that cycle is the old head.
REQ-021 Rejected requests (wr when full without rd, rd when empty) SHALL leave storage, pointers and count unchanged.
REQ-022 empty SHALL equal (count==0), full (count==2**W), almost_empty (count<=AE_LVL), almost_full (count>=AF_LVL), all derived from next-state count and registered.
REQ-023 Stored contents SHALL NOT be cleared by reset; only pointers, count and flags reset.

Reset
REQ-024 reset_n low SHALL immediately force pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued words; the first post-reset read sees empty.
REQ-026 valid SHALL be 0 during reset since empty=1.

Configuration
REQ-027 Macro FIFO_ERR_FLAGS_EN SHALL compile in sticky error flags.
REQ-028 With FIFO_ERR_FLAGS_EN: overflow sets at the edge after a rejected write, underflow after a rejected read; both hold until err_clr=1 (clears at next edge, set wins if simultaneous) or reset.
REQ-029 Without FIFO_ERR_FLAGS_EN: overflow and underflow SHALL be constant 0, err_clr ignored, no error registers present.

Verification (B=8, W=3, AF_LVL=6, AE_LVL=2)
REQ-030 Reset, then 8 writes 0x01..0x08 -> count 1..8, almost_empty drops at count 3, almost_full at count 6, full at count 8.
REQ-031 From full, wr=1 rd=0 with 0xAA -> contents unchanged, count 8; with FIFO_ERR_FLAGS_EN overflow=1 until err_clr.
REQ-032 From full, wr&rd with 0x09 -> valid=1, r_data=0x01, count stays 8; subsequent 8 reads return 0x02..0x09.
REQ-033 Empty, wr&rd with 0x55 -> valid=0, count 1, next cycle rd -> valid=1, r_data=0x55, empty=1 after.
REQ-034 16 writes/reads interleaved to wrap pointers twice -> data order preserved, no spurious full/empty.
REQ-035 Assert reset_n=0 at count 5 mid-stream -> count=0, empty=1 immediately; rd next -> valid=0, underflow=1 when enabled.
